// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer
//   Multi-cycle controller for the data-memory stage. Owns the stack pointer,
//   sequences PUSH/POP/CALL/RET/INT/RTI (multi-step stack traffic) and
//   single-cycle LD/ST, and stalls the requester via op_valid/op_ready.
//   Popped words land in PC/CCR restore registers or pop_data.
//
// Ports
//   i_clk, i_rst_n     clock (rising edge), asynchronous active-low reset
//   i_op_valid/code    request; code 0 LD,1 ST,2 PUSH,3 POP,4 CALL,5 RET,6 INT,7 RTI
//   o_op_ready         high only in IDLE
//   i_mem_rdata        read data, valid the cycle after o_mem_rd
//   o_mem_rd/o_mem_wr  data-memory strobes
//   o_addr_sel         0 stack address, 1 instruction address (LD/ST)
//   o_data_sel         00 ALU, 01 PC low, 10 PC high, 11 CCR
//   o_sp_addr          stack address presented this cycle
//   o_pc_restore       {high,low} popped by RET/RTI
//   o_ccr_restore      CCR popped by RTI
//   o_pop_data         word popped by POP/LD
//   o_op_done          one-cycle completion pulse
//   o_stack_err        one-cycle pulse on a blocked push/pop (guard build only)
//
// Build option
//   STACK_GUARD_EN : block pushes below STACK_LIMIT and pops from an empty
//                    stack; without it the pointer wraps silently.
module stack_op_sequencer #(
  parameter int                ADDR_W      = 12,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] SP_RESET    = 12'hFFF,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 12'h800
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_op_valid,
  input  logic [2:0]        i_op_code,
  output logic              o_op_ready,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic              o_addr_sel,
  output logic [1:0]        o_data_sel,
  output logic [ADDR_W-1:0] o_sp_addr,
  output logic [31:0]       o_pc_restore,
  output logic [2:0]        o_ccr_restore,
  output logic [DATA_W-1:0] o_pop_data,
  output logic              o_op_done,
  output logic              o_stack_err
);
  typedef enum logic [2:0] {S_IDLE, S_W1, S_W2, S_W3, S_R1, S_R2, S_R3, S_CAP} state_t;

  localparam logic [2:0] OP_LD = 3'd0, OP_ST = 3'd1, OP_PUSH = 3'd2, OP_POP = 3'd3,
                         OP_CALL = 3'd4, OP_RET = 3'd5, OP_INT = 3'd6, OP_RTI = 3'd7;

  state_t            r_state;
  logic [ADDR_W-1:0] r_sp;
  logic [2:0]        r_op;
  logic [15:0]       r_pc_hi, r_pc_lo;
  logic [2:0]        r_ccr;
  logic [DATA_W-1:0] r_pop;

  logic              w_wstep, w_rstep, w_push, w_pop;
  logic              w_blk_push, w_blk_pop, w_blocked;
  logic              w_last_w, w_last_r, w_cap_pc, w_cap_pop;
  logic [ADDR_W-1:0] w_sp_inc, w_sp_dec;

  assign w_wstep  = r_state inside {S_W1, S_W2, S_W3};
  assign w_rstep  = r_state inside {S_R1, S_R2, S_R3};
  // LD/ST use the instruction address and leave the stack pointer alone
  assign w_push   = w_wstep && (r_op != OP_ST);
  assign w_pop    = w_rstep && (r_op != OP_LD);
  assign w_sp_inc = r_sp + ADDR_W'(1);
  assign w_sp_dec = r_sp - ADDR_W'(1);

`ifdef STACK_GUARD_EN
  assign w_blk_push = w_push && (r_sp < STACK_LIMIT);
  assign w_blk_pop  = w_pop && (r_sp == SP_RESET);
`else
  assign w_blk_push = 1'b0;
  assign w_blk_pop  = 1'b0;
`endif
  assign w_blocked = w_blk_push | w_blk_pop;

  assign w_last_w = ((r_state == S_W1) && (r_op inside {OP_ST, OP_PUSH})) ||
                    ((r_state == S_W2) && (r_op == OP_CALL)) ||
                    (r_state == S_W3);
  assign w_last_r = ((r_state == S_R1) && (r_op inside {OP_LD, OP_POP})) ||
                    ((r_state == S_R2) && (r_op == OP_RET)) ||
                    (r_state == S_R3);
  assign w_cap_pc  = (r_op == OP_RET) || (r_op == OP_RTI);
  assign w_cap_pop = (r_op == OP_LD) || (r_op == OP_POP);

  assign o_op_ready  = (r_state == S_IDLE);
  assign o_mem_wr    = w_wstep && !w_blk_push;
  assign o_mem_rd    = w_rstep && !w_blk_pop;
  assign o_addr_sel  = (w_wstep || w_rstep) && (r_op inside {OP_LD, OP_ST});
  assign o_sp_addr   = w_pop ? w_sp_inc : r_sp;
  assign o_op_done   = (w_wstep && w_last_w) || (r_state == S_CAP) || w_blocked;
  assign o_stack_err = w_blocked;

  // CALL/INT push PC high first so RET/RTI pop low before high
  always_comb begin
    o_data_sel = 2'b00;
    case (r_state)
      S_W1:    if (r_op inside {OP_CALL, OP_INT}) o_data_sel = 2'b10;
      S_W2:    o_data_sel = 2'b01;
      S_W3:    o_data_sel = 2'b11;
      default: o_data_sel = 2'b00;
    endcase
  end

  // The last popped word arrives during CAPTURE; forward it so the restore
  // outputs are valid in the same cycle as op_done.
  assign o_pc_restore  = ((r_state == S_CAP) && w_cap_pc) ? {i_mem_rdata[15:0], r_pc_lo}
                                                          : {r_pc_hi, r_pc_lo};
  assign o_pop_data    = ((r_state == S_CAP) && w_cap_pop) ? i_mem_rdata : r_pop;
  assign o_ccr_restore = r_ccr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_sp    <= SP_RESET;
      r_op    <= OP_LD;
      r_pc_hi <= '0;
      r_pc_lo <= '0;
      r_ccr   <= '0;
      r_pop   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_op_valid) begin
          r_op    <= i_op_code;
          r_state <= (i_op_code inside {OP_LD, OP_POP, OP_RET, OP_RTI}) ? S_R1 : S_W1;
        end
        S_W1, S_W2, S_W3: begin
          if (w_push && !w_blocked) r_sp <= w_sp_dec;
          if (w_blocked || w_last_w) r_state <= S_IDLE;
          else                       r_state <= (r_state == S_W1) ? S_W2 : S_W3;
        end
        S_R1, S_R2, S_R3: begin
          if (w_pop && !w_blocked) r_sp <= w_sp_inc;
          // mem_rdata here holds the word from the previous read step
          if (r_state == S_R2) begin
            if (r_op == OP_RET) r_pc_lo <= i_mem_rdata[15:0];
            if (r_op == OP_RTI) r_ccr   <= i_mem_rdata[2:0];
          end
          if (r_state == S_R3) r_pc_lo <= i_mem_rdata[15:0];
          if (w_blocked)     r_state <= S_IDLE;
          else if (w_last_r) r_state <= S_CAP;
          else               r_state <= (r_state == S_R1) ? S_R2 : S_R3;
        end
        S_CAP: begin
          if (w_cap_pop) r_pop   <= i_mem_rdata;
          if (w_cap_pc)  r_pc_hi <= i_mem_rdata[15:0];
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_op_sequencer.sv
module tb_stack_op_sequencer;
  localparam logic [2:0] OP_LD = 3'd0, OP_ST = 3'd1, OP_PUSH = 3'd2, OP_POP = 3'd3,
                         OP_CALL = 3'd4, OP_RET = 3'd5, OP_INT = 3'd6, OP_RTI = 3'd7;
`ifdef STACK_GUARD_EN
  localparam logic [11:0] LIMIT = 12'hFFE;
  localparam int NV = 10;
`else
  localparam logic [11:0] LIMIT = 12'h800;
  localparam int NV = 12;
`endif
  localparam logic [15:0] PC_HI = 16'h0001, PC_LO = 16'h0040, CCR = 16'h0003;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'd0;
  logic        op_ready, mem_rd, mem_wr, addr_sel, op_done, stack_err;
  logic [15:0] mem_rdata = 16'h0;
  logic [1:0]  data_sel;
  logic [11:0] sp_addr;
  logic [31:0] pc_restore;
  logic [2:0]  ccr_restore;
  logic [15:0] pop_data;

  logic [15:0] alu = 16'h0;
  logic [11:0] iaddr = 12'h0;
  logic [15:0] mem [4096];
  int          wr_count = 0;

  stack_op_sequencer #(.ADDR_W(12), .DATA_W(16), .SP_RESET(12'hFFF), .STACK_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_op_valid(op_valid), .i_op_code(op_code),
    .o_op_ready(op_ready), .i_mem_rdata(mem_rdata), .o_mem_rd(mem_rd), .o_mem_wr(mem_wr),
    .o_addr_sel(addr_sel), .o_data_sel(data_sel), .o_sp_addr(sp_addr),
    .o_pc_restore(pc_restore), .o_ccr_restore(ccr_restore), .o_pop_data(pop_data),
    .o_op_done(op_done), .o_stack_err(stack_err));

  always #5 clk = ~clk;

  // Memory model: write data chosen by data_sel, read data one cycle later
  wire [11:0] eff_addr = addr_sel ? iaddr : sp_addr;
  logic [15:0] wdata;
  always_comb begin
    case (data_sel)
      2'b00:   wdata = alu;
      2'b01:   wdata = PC_LO;
      2'b10:   wdata = PC_HI;
      default: wdata = CCR;
    endcase
  end
  always @(posedge clk) begin
    if (mem_wr) begin
      mem[eff_addr] <= wdata;
      wr_count <= wr_count + 1;
    end
    if (mem_rd) mem_rdata <= mem[eff_addr];
  end

  int n_pass = 0, n_tot = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Per-cycle trace of one operation, cycles 1..6 after accept
  logic        tr_wr [1:6], tr_rd [1:6];
  logic [11:0] tr_addr [1:6];
  logic [1:0]  tr_dsel [1:6];
  int          done_cyc, nwr, nrd, nerr;
  logic [15:0] dn_pop;
  logic [31:0] dn_pc;
  logic [2:0]  dn_ccr;
  logic        idle_rdy;
  logic [11:0] idle_sp;

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [11:0] ia);
    alu = a; iaddr = ia; op_valid = 1'b1; op_code = op;
    @(posedge clk); #1 op_valid = 1'b0;
    done_cyc = 0; nwr = 0; nrd = 0; nerr = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      tr_wr[c] = mem_wr; tr_rd[c] = mem_rd; tr_addr[c] = eff_addr; tr_dsel[c] = data_sel;
      if (mem_wr) nwr++;
      if (mem_rd) nrd++;
      if (stack_err) nerr++;
      if (op_done) begin
        done_cyc = c; dn_pop = pop_data; dn_pc = pc_restore; dn_ccr = ccr_restore;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    idle_rdy = op_ready; idle_sp = sp_addr;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] alu;
    logic [11:0] ia;
    int          len, nwr, nrd;
    logic [11:0] sp;
    int          kind;   // 0 none, 1 pop_data, 2 pc_restore
    logic [31:0] res;
  } vec_t;
  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{OP_PUSH, 16'h1234, 12'h000, 1, 1, 0, 12'hFFE, 0, 32'h0};
    tbl[1]  = '{OP_POP,  16'h0000, 12'h000, 2, 0, 1, 12'hFFF, 1, 32'h1234};
    tbl[2]  = '{OP_ST,   16'hBEEF, 12'h010, 1, 1, 0, 12'hFFF, 0, 32'h0};
    tbl[3]  = '{OP_LD,   16'h0000, 12'h010, 2, 0, 1, 12'hFFF, 1, 32'hBEEF};
    tbl[4]  = '{OP_CALL, 16'h0000, 12'h000, 2, 2, 0, 12'hFFD, 0, 32'h0};
    tbl[5]  = '{OP_RET,  16'h0000, 12'h000, 3, 0, 2, 12'hFFF, 2, 32'h0001_0040};
    tbl[6]  = '{OP_PUSH, 16'hAAAA, 12'h000, 1, 1, 0, 12'hFFE, 0, 32'h0};
    tbl[7]  = '{OP_PUSH, 16'h5555, 12'h000, 1, 1, 0, 12'hFFD, 0, 32'h0};
    tbl[8]  = '{OP_POP,  16'h0000, 12'h000, 2, 0, 1, 12'hFFE, 1, 32'h5555};
    tbl[9]  = '{OP_POP,  16'h0000, 12'h000, 2, 0, 1, 12'hFFF, 1, 32'hAAAA};
    // unguarded build: pop from empty stack wraps to 000, push at 000 wraps back
    tbl[10] = '{OP_POP,  16'h0000, 12'h000, 2, 0, 1, 12'h000, 0, 32'h0};
    tbl[11] = '{OP_PUSH, 16'h7777, 12'h000, 1, 1, 0, 12'hFFF, 0, 32'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst sp_addr", sp_addr, 12'hFFF);
    chk("rst op_ready", op_ready, 1'b1);
    chk("rst strobes", {mem_rd, mem_wr, op_done, stack_err}, 4'b0);
    chk("rst sels", {addr_sel, data_sel}, 3'b0);
    chk("rst restore", {pc_restore, ccr_restore, pop_data}, 51'h0);
    @(posedge clk); #1;

    // CALL from FFF: PC high then PC low
    run_op(OP_CALL, 16'h0, 12'h0);
    chk("call c1", {tr_wr[1], tr_addr[1], tr_dsel[1]}, {1'b1, 12'hFFF, 2'b10});
    chk("call c2", {tr_wr[2], tr_addr[2], tr_dsel[2]}, {1'b1, 12'hFFE, 2'b01});
    chk("call done", done_cyc, 2);
    chk("call idle", {idle_rdy, idle_sp}, {1'b1, 12'hFFD});
    run_op(OP_RET, 16'h0, 12'h0);
    chk("ret rd addrs", {tr_rd[1], tr_addr[1], tr_rd[2], tr_addr[2]}, {1'b1, 12'hFFE, 1'b1, 12'hFFF});
    chk("ret pc", dn_pc, 32'h0001_0040);

    // Table-driven sequence
    for (int i = 0; i < NV; i++) begin
      run_op(tbl[i].op, tbl[i].alu, tbl[i].ia);
      chk($sformatf("row%0d done", i), done_cyc, tbl[i].len);
      chk($sformatf("row%0d nwr", i), nwr, tbl[i].nwr);
      chk($sformatf("row%0d nrd", i), nrd, tbl[i].nrd);
      chk($sformatf("row%0d err", i), nerr, 0);
      chk($sformatf("row%0d idle", i), {idle_rdy, idle_sp}, {1'b1, tbl[i].sp});
      if (tbl[i].kind == 1) chk($sformatf("row%0d pop", i), dn_pop, tbl[i].res[15:0]);
      if (tbl[i].kind == 2) chk($sformatf("row%0d pc", i), dn_pc, tbl[i].res);
    end

`ifndef STACK_GUARD_EN
    // INT then RTI
    run_op(OP_INT, 16'h0, 12'h0);
    chk("int dsel", {tr_dsel[1], tr_dsel[2], tr_dsel[3]}, 6'b10_01_11);
    chk("int addrs", {tr_addr[1], tr_addr[2], tr_addr[3]}, {12'hFFF, 12'hFFE, 12'hFFD});
    chk("int done", {done_cyc, nwr}, {32'd3, 32'd3});
    chk("int sp", idle_sp, 12'hFFC);
    run_op(OP_RTI, 16'h0, 12'h0);
    chk("rti done", done_cyc, 4);
    chk("rti addrs", {tr_addr[1], tr_addr[2], tr_addr[3]}, {12'hFFD, 12'hFFE, 12'hFFF});
    chk("rti ccr", dn_ccr, 3'b011);
    chk("rti pc", dn_pc, 32'h0001_0040);
    chk("rti sp", {idle_rdy, idle_sp}, {1'b1, 12'hFFF});
`else
    // Guard: CALL fills FFF/FFE, PUSH at FFD is below the limit
    run_op(OP_CALL, 16'h0, 12'h0);
    chk("g call", {done_cyc, nwr, nerr}, {32'd2, 32'd2, 32'd0});
    chk("g call sp", idle_sp, 12'hFFD);
    run_op(OP_PUSH, 16'h9999, 12'h0);
    chk("g push", {done_cyc, nwr, nerr}, {32'd1, 32'd0, 32'd1});
    chk("g push sp", {idle_rdy, idle_sp}, {1'b1, 12'hFFD});
    run_op(OP_RET, 16'h0, 12'h0);
    chk("g ret sp", idle_sp, 12'hFFF);
    run_op(OP_POP, 16'h0, 12'h0);
    chk("g pop", {done_cyc, nrd, nerr}, {32'd1, 32'd0, 32'd1});
    chk("g pop sp", {idle_rdy, idle_sp}, {1'b1, 12'hFFF});
`endif

    // Reset in the middle of INT
    begin
      int base, stray;
      alu = 16'h0; iaddr = 12'h0; op_valid = 1'b1; op_code = OP_INT;
      @(posedge clk); #1 op_valid = 1'b0;
      @(negedge clk);
      chk("int-rst c1", {mem_wr, eff_addr}, {1'b1, 12'hFFF});
      @(posedge clk); #1 rst_n = 1'b0;
      base = wr_count; stray = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (mem_wr || mem_rd) stray++;
      end
      @(posedge clk); #1 rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (mem_wr || mem_rd) stray++;
      end
      chk("int-rst strobes", stray, 0);
      chk("int-rst wr_count", wr_count, base);
      chk("int-rst idle", {op_ready, sp_addr}, {1'b1, 12'hFFF});
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
